abr_masked_add_sub_mod_ctrl: RTL and testbench
==============================================

Name: abr_masked_add_sub_mod_ctrl

Overview:
Sequencer for the masked Boolean modular add/sub datapath (q = 8380417, 23-bit two-share operands).
- On each start, streams NUM_COEFF coefficient pairs from memory into the fixed-latency, non-stallable datapath.
- Gates each issue on availability of fresh mask randomness.
- Tracks in-flight items with a valid pipeline and generates destination write strobes and addresses when results emerge.
- Pulses done after the last write.

Parameters:
NUM_COEFF, 256, coefficients per operation
ADDR_W, 8, memory address width
DP_LATENCY, 53, datapath input-to-output latency in cycles; must equal the instantiated datapath configuration
MEM_RD_LAT, 1, source memory read latency in cycles

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
zeroize  in  1  synchronous clear of all state
start_i  in  1  start pulse, sampled in IDLE only
sub_mode_i  in  1  1 = subtract, 0 = add; latched at start
src_a_base_i  in  ADDR_W  operand A base address, latched at start
src_b_base_i  in  ADDR_W  operand B base address, latched at start
dst_base_i  in  ADDR_W  result base address, latched at start
rnd_valid_i  in  1  fresh 3*WIDTH randomness present this cycle
rnd_req_o  out  1  randomness consumed this cycle
mem_rd_en_o  out  1  source read strobe
mem_rd_addr_a_o  out  ADDR_W  operand A read address
mem_rd_addr_b_o  out  ADDR_W  operand B read address
dp_sub_o  out  1  datapath sub_i, held stable for the whole operation
mem_wr_en_o  out  1  result write strobe
mem_wr_addr_o  out  ADDR_W  result write address
busy_o  out  1  operation in progress
done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset and zeroize values: all outputs 0; FSM in IDLE; counters, valid pipeline and latched registers cleared.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start_i=1 latches sub_mode_i and the three base addresses, clears counters, and moves to ISSUE.
  - busy_o rises the next cycle.
- ISSUE:
  - Each cycle with rnd_valid_i=1: assert mem_rd_en_o and rnd_req_o in the same cycle.
  - Read addresses are src_*_base + issue_cnt, modulo 2^ADDR_W (wrap allowed).
  - issue_cnt increments on each issue.
  - rnd_valid_i=0 inserts a bubble: no read and no request. The pipeline never stalls.
  - After issue number NUM_COEFF, move to DRAIN.
- Valid pipeline:
  - Shift register of length MEM_RD_LAT+DP_LATENCY, shifting every cycle; its input is the issue strobe.
  - Its output drives mem_wr_en_o.
  - mem_wr_addr_o = dst_base + wr_cnt (mod 2^ADDR_W); wr_cnt increments per write.
  - Write order equals issue order, with bubbles preserved.
- DRAIN: once wr_cnt reaches NUM_COEFF, move to DONE.
- DONE: done_o=1 for exactly one cycle, busy_o=0, then return to IDLE.
  - A start_i in that same cycle is ignored; start is accepted only in IDLE.
- busy_o is 1 in ISSUE and DRAIN only.
- dp_sub_o:
  - Equals the latched mode from the first issue until the last write.
  - Never changes while any item is in flight.
  - Holds its value in IDLE (the datapath's combinational sub muxing must not glitch across drain).
- Minimum latency with rnd_valid_i held at 1: start to done = 1 + NUM_COEFF + MEM_RD_LAT + DP_LATENCY cycles.
- start_i while busy: ignored, with no effect on latched values.
- zeroize: has priority over all events, including a simultaneous start.
  - Mid-operation, it abandons the operation: valid pipeline flushed, no further writes, no done pulse, return to IDLE.
- Reset mid-operation: identical to zeroize, but asynchronous.
- No address is ever written twice, and no write occurs outside [dst_base, dst_base+NUM_COEFF-1] mod 2^ADDR_W.

Decomposition:
- Shared package abr_params_pkg holds:
  - the FSM state enum (IDLE, ISSUE, DRAIN, DONE);
  - the MLDSA_Q constant;
  - the default DP_LATENCY tied to the datapath width (WIDTH=23).
- One sub-module, abr_valid_pipe (parameterized-depth 1-bit shift register with synchronous flush), implements the in-flight tracking.
- Counters and the FSM remain in the top module.

Test Plan:
- Add, contiguous rnd: start with sub_mode=0, bases A=0x00, B=0x00, D=0x00, rnd_valid held 1.
  - 256 reads on consecutive cycles.
  - First write exactly 1+DP_LATENCY cycles after first read, address 0x00.
  - Last write at 0xFF; done exactly one cycle after the last write.
  - Reference-model results: (a+b) mod 8380417, e.g. 8380416+1 = 0.
- Subtract with bubbles: sub_mode=1, rnd_valid random at 50%.
  - Exactly 256 rnd_req pulses.
  - Write pattern equals the read pattern delayed by 1+DP_LATENCY.
  - dp_sub_o stays 1 throughout.
  - Results: 0-1 = 8380416.
- Wrap-around: A=0xF0, D=0x80.
  - Read addresses wrap from 0xFF to 0x00.
  - Writes cover 0x80..0x7F mod 256 with no duplicates.
- Zeroize at issue count 100: all strobes 0 the next cycle, no done, busy_o=0.
  - A new start then completes normally with 256 writes.
- Start while busy and start during the DONE cycle: both ignored.
  - Latched bases are unchanged; exactly one done pulse.
- Async rst_n asserted mid-DRAIN: outputs 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/abr_params_pkg.sv
// Shared constants and types for the masked Boolean modular add/sub block.
package abr_params_pkg;

  localparam int unsigned MLDSA_WIDTH = 23;
  localparam logic [MLDSA_WIDTH-1:0] MLDSA_Q = 23'd8380417;

  // Datapath latency for the WIDTH=23 two-share add/sub configuration (53 cycles)
  localparam int unsigned MLDSA_DP_LATENCY = 2 * MLDSA_WIDTH + 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } abr_ctrl_state_e;

endpackage

// File: rtl/abr_valid_pipe.sv
// Fixed-depth 1-bit valid shift register with synchronous flush.
module abr_valid_pipe #(
  parameter int unsigned DEPTH = 54
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_i,
  input  logic valid_i,
  output logic valid_o
);

  logic [DEPTH-1:0] pipe_q;
  logic [DEPTH-1:0] pipe_d;

  generate
    if (DEPTH == 1) begin : g_single
      always_comb pipe_d = flush_i ? '0 : valid_i;
    end else begin : g_multi
      always_comb pipe_d = flush_i ? '0 : {pipe_q[DEPTH-2:0], valid_i};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe_q <= '0;
    else        pipe_q <= pipe_d;
  end

  assign valid_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/abr_masked_add_sub_mod_ctrl.sv
// Sequencer for the masked modular add/sub datapath: issues reads gated on
// randomness, tracks in-flight items and generates result writes.
module abr_masked_add_sub_mod_ctrl
  import abr_params_pkg::*;
#(
  parameter int unsigned NUM_COEFF  = 256,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DP_LATENCY = MLDSA_DP_LATENCY,
  parameter int unsigned MEM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              zeroize,
  input  logic              start_i,
  input  logic              sub_mode_i,
  input  logic [ADDR_W-1:0] src_a_base_i,
  input  logic [ADDR_W-1:0] src_b_base_i,
  input  logic [ADDR_W-1:0] dst_base_i,
  input  logic              rnd_valid_i,
  output logic              rnd_req_o,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_rd_addr_a_o,
  output logic [ADDR_W-1:0] mem_rd_addr_b_o,
  output logic              dp_sub_o,
  output logic              mem_wr_en_o,
  output logic [ADDR_W-1:0] mem_wr_addr_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned CNT_W      = $clog2(NUM_COEFF + 1);
  localparam int unsigned PIPE_DEPTH = MEM_RD_LAT + DP_LATENCY;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_COEFF - 1);

  abr_ctrl_state_e   state_q, state_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] src_a_base_q, src_a_base_d;
  logic [ADDR_W-1:0] src_b_base_q, src_b_base_d;
  logic [ADDR_W-1:0] dst_base_q, dst_base_d;
  logic              dp_sub_q, dp_sub_d;
  logic              issue;
  logic              wr_en;

  assign issue = (state_q == ST_ISSUE) && rnd_valid_i;

  abr_valid_pipe #(
    .DEPTH (PIPE_DEPTH)
  ) u_valid_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (zeroize),
    .valid_i (issue),
    .valid_o (wr_en)
  );

  always_comb begin
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    wr_cnt_d     = wr_cnt_q;
    src_a_base_d = src_a_base_q;
    src_b_base_d = src_b_base_q;
    dst_base_d   = dst_base_q;
    dp_sub_d     = dp_sub_q;

    if (wr_en) wr_cnt_d = wr_cnt_q + CNT_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          src_a_base_d = src_a_base_i;
          src_b_base_d = src_b_base_i;
          dst_base_d   = dst_base_i;
          dp_sub_d     = sub_mode_i;
          issue_cnt_d  = '0;
          wr_cnt_d     = '0;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (issue) begin
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
          if (issue_cnt_q == LAST_IDX) state_d = ST_DRAIN;
        end
      end
      // Leave DRAIN on the final write itself so done follows it by one cycle
      ST_DRAIN: begin
        if (wr_en && (wr_cnt_q == LAST_IDX)) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (zeroize) begin
      state_d      = ST_IDLE;
      issue_cnt_d  = '0;
      wr_cnt_d     = '0;
      src_a_base_d = '0;
      src_b_base_d = '0;
      dst_base_d   = '0;
      dp_sub_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      issue_cnt_q  <= '0;
      wr_cnt_q     <= '0;
      src_a_base_q <= '0;
      src_b_base_q <= '0;
      dst_base_q   <= '0;
      dp_sub_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      src_a_base_q <= src_a_base_d;
      src_b_base_q <= src_b_base_d;
      dst_base_q   <= dst_base_d;
      dp_sub_q     <= dp_sub_d;
    end
  end

  assign rnd_req_o       = issue;
  assign mem_rd_en_o     = issue;
  assign mem_rd_addr_a_o = issue ? src_a_base_q + ADDR_W'(issue_cnt_q) : '0;
  assign mem_rd_addr_b_o = issue ? src_b_base_q + ADDR_W'(issue_cnt_q) : '0;
  assign mem_wr_en_o     = wr_en;
  assign mem_wr_addr_o   = wr_en ? dst_base_q + ADDR_W'(wr_cnt_q) : '0;
  assign dp_sub_o        = dp_sub_q;
  assign busy_o          = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign done_o          = (state_q == ST_DONE);

endmodule

// File: tb/tb_abr_masked_add_sub_mod_ctrl.sv
// Randomized bench for abr_masked_add_sub_mod_ctrl with a queue-based datapath/memory model.
module tb_abr_masked_add_sub_mod_ctrl;

  localparam int unsigned NUM = 256;
  localparam int unsigned DPL = 53;
  localparam int unsigned MRL = 1;
  localparam int unsigned Q   = 8380417;
  localparam int unsigned LAT = 1 + NUM + MRL + DPL;

  logic       clk, rst_n, zeroize, start_i, sub_mode_i, rnd_valid_i;
  logic [7:0] src_a_base_i, src_b_base_i, dst_base_i;
  logic       rnd_req_o, mem_rd_en_o, dp_sub_o, mem_wr_en_o, busy_o, done_o;
  logic [7:0] mem_rd_addr_a_o, mem_rd_addr_b_o, mem_wr_addr_o;
  logic [29:0] outs;

  abr_masked_add_sub_mod_ctrl #(
    .NUM_COEFF  (NUM),
    .ADDR_W     (8),
    .DP_LATENCY (DPL),
    .MEM_RD_LAT (MRL)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .zeroize         (zeroize),
    .start_i         (start_i),
    .sub_mode_i      (sub_mode_i),
    .src_a_base_i    (src_a_base_i),
    .src_b_base_i    (src_b_base_i),
    .dst_base_i      (dst_base_i),
    .rnd_valid_i     (rnd_valid_i),
    .rnd_req_o       (rnd_req_o),
    .mem_rd_en_o     (mem_rd_en_o),
    .mem_rd_addr_a_o (mem_rd_addr_a_o),
    .mem_rd_addr_b_o (mem_rd_addr_b_o),
    .dp_sub_o        (dp_sub_o),
    .mem_wr_en_o     (mem_wr_en_o),
    .mem_wr_addr_o   (mem_wr_addr_o),
    .busy_o          (busy_o),
    .done_o          (done_o)
  );

  assign outs = {busy_o, done_o, rnd_req_o, mem_rd_en_o, mem_wr_en_o, dp_sub_o,
                 mem_rd_addr_a_o, mem_rd_addr_b_o, mem_wr_addr_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int unsigned cyc; int unsigned a; int unsigned b; } rd_t;
  typedef struct { int unsigned a; int unsigned b; bit sub; } op_t;

  int unsigned mem_a [NUM];
  int unsigned mem_b [NUM];
  int unsigned dst   [NUM];
  int unsigned hits  [NUM];
  rd_t         rd_q[$];
  op_t         dp_q[$];
  int unsigned wr_cyc_q[$];
  int unsigned wr_addr_q[$];

  int unsigned cyc, n_req, req_mismatch, done_cnt, done_cyc, sub_err, orphan;
  bit          exp_mode;
  int unsigned n_checks, n_fail;
  int unsigned rd_addr_err, wr_addr_err, delay_err, res_err, dup_cnt, once_cnt;

  function automatic int unsigned ref_addsub(int unsigned a, int unsigned b, bit sub);
    return sub ? (a + Q - b) % Q : (a + b) % Q;
  endfunction

  // Memory + datapath model: operands captured at read, result applied in FIFO order at write
  always @(negedge clk) begin
    op_t o;
    cyc++;
    if (mem_rd_en_o !== rnd_req_o) req_mismatch++;
    if (rnd_req_o === 1'b1) n_req++;
    if (mem_rd_en_o === 1'b1) begin
      rd_q.push_back('{cyc, 32'(mem_rd_addr_a_o), 32'(mem_rd_addr_b_o)});
      dp_q.push_back('{mem_a[mem_rd_addr_a_o], mem_b[mem_rd_addr_b_o], dp_sub_o});
    end
    if (mem_wr_en_o === 1'b1) begin
      wr_cyc_q.push_back(cyc);
      wr_addr_q.push_back(32'(mem_wr_addr_o));
      hits[mem_wr_addr_o]++;
      if (dp_q.size() > 0) begin
        o = dp_q.pop_front();
        dst[mem_wr_addr_o] = ref_addsub(o.a, o.b, o.sub);
      end else orphan++;
    end
    if (done_o === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if ((busy_o === 1'b1 || mem_wr_en_o === 1'b1) && dp_sub_o !== exp_mode) sub_err++;
  end

  task automatic clear_stats();
    rd_q.delete(); dp_q.delete(); wr_cyc_q.delete(); wr_addr_q.delete();
    for (int i = 0; i < NUM; i++) begin dst[i] = 0; hits[i] = 0; end
    n_req = 0; req_mismatch = 0; done_cnt = 0; done_cyc = 0; sub_err = 0; orphan = 0;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < NUM; i++) begin
      mem_a[i] = $urandom_range(Q - 1);
      mem_b[i] = $urandom_range(Q - 1);
    end
  endtask

  // Derive per-operation statistics from the recorded traffic
  task automatic scan_op(input int unsigned a, input int unsigned b, input int unsigned d);
    rd_addr_err = 0; wr_addr_err = 0; delay_err = 0; res_err = 0; dup_cnt = 0; once_cnt = 0;
    for (int i = 0; i < rd_q.size(); i++)
      if (rd_q[i].a != (a + i) % NUM || rd_q[i].b != (b + i) % NUM) rd_addr_err++;
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      if (wr_addr_q[i] != (d + i) % NUM) wr_addr_err++;
      if (i >= rd_q.size() || wr_cyc_q[i] != rd_q[i].cyc + MRL + DPL) delay_err++;
    end
    for (int i = 0; i < NUM; i++) begin
      if (hits[i] > 1) dup_cnt++;
      if (hits[i] == 1) once_cnt++;
      if (dst[(d + i) % NUM] != ref_addsub(mem_a[(a + i) % NUM], mem_b[(b + i) % NUM], exp_mode))
        res_err++;
    end
  endtask

  task automatic run_op(input bit mode, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] d, input int unsigned pct,
                        input int unsigned busy_start_at, input bit done_start,
                        output int unsigned c0);
    int unsigned rel;
    bit          finished;
    finished = 1'b0;
    exp_mode = mode;
    @(posedge clk); #1;
    start_i = 1'b1; sub_mode_i = mode;
    src_a_base_i = a; src_b_base_i = b; dst_base_i = d;
    rnd_valid_i = ($urandom_range(99) < pct);
    @(negedge clk); #1;
    c0 = cyc;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #1;
      if (done_cnt != 0) begin finished = 1'b1; break; end
      start_i = 1'b0;
      rnd_valid_i = ($urandom_range(99) < pct);
      rel = cyc + 1 - c0;
      if ((busy_start_at != 0 && rel == busy_start_at) || (done_start && rel == LAT)) begin
        start_i = 1'b1; sub_mode_i = ~mode;
        src_a_base_i = ~a; src_b_base_i = ~b; dst_base_i = ~d;
      end
    end
    start_i = 1'b0; rnd_valid_i = 1'b0;
    if (!finished) begin
      n_checks++; n_fail++;
      $display("FAIL op_timeout: no done within bound (done_cnt=%0d)", done_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs); end
    @(posedge clk); #1;
    rst_n = 1'b1; rnd_valid_i = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy_o, mem_rd_en_o, rnd_req_o} !== 3'b000) begin
      n_fail++; $display("FAIL idle_ignores_rnd: got %b expected 000", {busy_o, mem_rd_en_o, rnd_req_o});
    end
    rnd_valid_i = 1'b0;
  endtask

  task automatic test_add_contig();
    int unsigned c0, bad_seq;
    clear_stats(); fill_mem();
    mem_a[0] = Q - 1; mem_b[0] = 1;
    run_op(1'b0, 8'h00, 8'h00, 8'h00, 100, 0, 1'b0, c0);
    scan_op(0, 0, 0);
    bad_seq = 0;
    for (int i = 0; i < rd_q.size(); i++) if (rd_q[i].cyc != c0 + 1 + i) bad_seq++;
    n_checks++;
    if (rd_q.size() != NUM || bad_seq != 0) begin
      n_fail++; $display("FAIL add_reads: got %0d reads (%0d non-consecutive) expected %0d", rd_q.size(), bad_seq, NUM);
    end
    n_checks++;
    if (rd_addr_err != 0) begin n_fail++; $display("FAIL add_rd_addr: got %0d errors expected 0", rd_addr_err); end
    n_checks++;
    if (wr_cyc_q.size() == 0 || wr_cyc_q[0] != rd_q[0].cyc + 1 + DPL || wr_addr_q[0] != 0) begin
      n_fail++; $display("FAIL add_first_write: got %0d writes expected first at read+%0d addr 0", wr_cyc_q.size(), 1 + DPL);
    end
    n_checks++;
    if (wr_addr_q.size() != NUM || wr_addr_err != 0 || wr_addr_q[wr_addr_q.size()-1] != 8'hFF) begin
      n_fail++; $display("FAIL add_writes: got %0d writes, %0d addr errors expected %0d, 0", wr_addr_q.size(), wr_addr_err, NUM);
    end
    n_checks++;
    if (done_cnt != 1 || done_cyc != wr_cyc_q[wr_cyc_q.size()-1] + 1) begin
      n_fail++; $display("FAIL add_done_after_last_write: got cnt %0d cyc %0d expected 1 at last write+1", done_cnt, done_cyc);
    end
    n_checks++;
    if (done_cyc - c0 != LAT) begin n_fail++; $display("FAIL add_latency: got %0d expected %0d", done_cyc - c0, LAT); end
    n_checks++;
    if (dst[0] != 0) begin n_fail++; $display("FAIL add_wrap_q: got %0d expected 0", dst[0]); end
    n_checks++;
    if (res_err != 0 || orphan != 0) begin
      n_fail++; $display("FAIL add_results: got %0d errors %0d orphans expected 0", res_err, orphan);
    end
    n_checks++;
    if (req_mismatch != 0 || sub_err != 0) begin
      n_fail++; $display("FAIL add_req_sub: got req_mm %0d sub_err %0d expected 0", req_mismatch, sub_err);
    end
  endtask

  task automatic test_sub_bubbles();
    int unsigned c0;
    clear_stats(); fill_mem();
    mem_a[8'h20] = 0; mem_b[8'h40] = 1;
    run_op(1'b1, 8'h20, 8'h40, 8'h00, 50, 0, 1'b0, c0);
    scan_op(8'h20, 8'h40, 8'h00);
    n_checks++;
    if (n_req != NUM) begin n_fail++; $display("FAIL sub_rnd_req: got %0d expected %0d", n_req, NUM); end
    n_checks++;
    if (wr_addr_q.size() != NUM || delay_err != 0) begin
      n_fail++; $display("FAIL sub_write_pattern: got %0d writes %0d delay errors expected %0d, 0", wr_addr_q.size(), delay_err, NUM);
    end
    n_checks++;
    if (sub_err != 0) begin n_fail++; $display("FAIL sub_dp_sub_stable: got %0d glitches expected 0", sub_err); end
    n_checks++;
    if (dst[0] != Q - 1) begin n_fail++; $display("FAIL sub_zero_minus_one: got %0d expected %0d", dst[0], Q - 1); end
    n_checks++;
    if (res_err != 0 || done_cnt != 1) begin
      n_fail++; $display("FAIL sub_results: got %0d errors done %0d expected 0, 1", res_err, done_cnt);
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (dp_sub_o !== 1'b1) begin n_fail++; $display("FAIL sub_hold_idle: got %b expected 1", dp_sub_o); end
  endtask

  task automatic test_wraparound();
    int unsigned c0;
    clear_stats(); fill_mem();
    run_op(1'b0, 8'hF0, 8'h33, 8'h80, 80, 0, 1'b0, c0);
    scan_op(8'hF0, 8'h33, 8'h80);
    n_checks++;
    if (rd_q.size() != NUM || rd_q[15].a != 8'hFF || rd_q[16].a != 8'h00 || rd_addr_err != 0) begin
      n_fail++; $display("FAIL wrap_rd_addr: got %0d reads %0d errors expected %0d wrapping at 16", rd_q.size(), rd_addr_err, NUM);
    end
    n_checks++;
    if (dup_cnt != 0 || once_cnt != NUM || wr_addr_err != 0) begin
      n_fail++; $display("FAIL wrap_wr_cover: got dup %0d once %0d err %0d expected 0, %0d, 0", dup_cnt, once_cnt, wr_addr_err, NUM);
    end
    n_checks++;
    if (res_err != 0) begin n_fail++; $display("FAIL wrap_results: got %0d errors expected 0", res_err); end
  endtask

  task automatic test_zeroize();
    int unsigned c0, n_wr_snap;
    clear_stats(); fill_mem();
    exp_mode = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b1; sub_mode_i = 1'b0;
    src_a_base_i = 8'h10; src_b_base_i = 8'h20; dst_base_i = 8'h30; rnd_valid_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int k = 0; k < 400 && rd_q.size() != 100; k++) begin @(posedge clk); #1; end
    n_checks++;
    if (rd_q.size() != 100) begin n_fail++; $display("FAIL zero_reach_100: got %0d reads expected 100", rd_q.size()); end
    zeroize = 1'b1;
    @(posedge clk); #1;
    zeroize = 1'b0;
    @(negedge clk);
    n_wr_snap = wr_addr_q.size();
    n_checks++;
    if ({mem_rd_en_o, rnd_req_o, mem_wr_en_o, done_o, busy_o} !== 5'b0) begin
      n_fail++; $display("FAIL zero_strobes: got %b expected 00000", {mem_rd_en_o, rnd_req_o, mem_wr_en_o, done_o, busy_o});
    end
    repeat (80) @(negedge clk);
    n_checks++;
    if (wr_addr_q.size() != n_wr_snap || done_cnt != 0) begin
      n_fail++; $display("FAIL zero_abandon: got %0d extra writes done %0d expected 0, 0", wr_addr_q.size() - n_wr_snap, done_cnt);
    end
    @(posedge clk); #1;
    start_i = 1'b1; zeroize = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; zeroize = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy_o, mem_rd_en_o} !== 2'b00) begin
      n_fail++; $display("FAIL zero_beats_start: got %b expected 00", {busy_o, mem_rd_en_o});
    end
    rnd_valid_i = 1'b0;
    clear_stats();
    run_op(1'b0, 8'h10, 8'h20, 8'h30, 70, 0, 1'b0, c0);
    scan_op(8'h10, 8'h20, 8'h30);
    n_checks++;
    if (wr_addr_q.size() != NUM || wr_addr_err != 0 || res_err != 0 || done_cnt != 1) begin
      n_fail++; $display("FAIL zero_restart: got %0d writes %0d/%0d errors done %0d expected %0d, 0/0, 1",
                         wr_addr_q.size(), wr_addr_err, res_err, done_cnt, NUM);
    end
  endtask

  task automatic test_busy_start();
    int unsigned c0, busy_seen;
    clear_stats(); fill_mem();
    run_op(1'b1, 8'h05, 8'h06, 8'h07, 100, 40, 1'b1, c0);
    scan_op(8'h05, 8'h06, 8'h07);
    n_checks++;
    if (rd_addr_err != 0 || wr_addr_err != 0 || sub_err != 0 || res_err != 0) begin
      n_fail++; $display("FAIL busy_start_latched: got rd %0d wr %0d sub %0d res %0d errors expected 0",
                         rd_addr_err, wr_addr_err, sub_err, res_err);
    end
    n_checks++;
    if (done_cyc - c0 != LAT) begin n_fail++; $display("FAIL busy_start_latency: got %0d expected %0d", done_cyc - c0, LAT); end
    busy_seen = 0;
    rnd_valid_i = 1'b1;
    for (int k = 0; k < 30; k++) begin @(negedge clk); if (busy_o === 1'b1) busy_seen++; end
    rnd_valid_i = 1'b0;
    n_checks++;
    if (busy_seen != 0 || done_cnt != 1 || rd_q.size() != NUM) begin
      n_fail++; $display("FAIL done_cycle_start: got busy %0d done %0d reads %0d expected 0, 1, %0d",
                         busy_seen, done_cnt, rd_q.size(), NUM);
    end
  endtask

  task automatic test_async_reset();
    int unsigned n_wr_snap;
    clear_stats(); fill_mem();
    exp_mode = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b1; sub_mode_i = 1'b1;
    src_a_base_i = 8'h40; src_b_base_i = 8'h50; dst_base_i = 8'h60; rnd_valid_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int k = 0; k < 600 && (rd_q.size() != NUM || wr_addr_q.size() < 210); k++) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (busy_o !== 1'b1 || rd_q.size() != NUM) begin
      n_fail++; $display("FAIL async_reach_drain: got busy %b reads %0d expected 1, %0d", busy_o, rd_q.size(), NUM);
    end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (outs !== '0) begin n_fail++; $display("FAIL async_rst_outputs: got %h expected 0", outs); end
    @(negedge clk);
    rst_n = 1'b1;
    n_wr_snap = wr_addr_q.size();
    repeat (80) @(negedge clk);
    n_checks++;
    if (wr_addr_q.size() != n_wr_snap || done_cnt != 0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL async_abandon: got %0d extra writes done %0d busy %b expected 0, 0, 0",
                         wr_addr_q.size() - n_wr_snap, done_cnt, busy_o);
    end
    rnd_valid_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; zeroize = 1'b0; start_i = 1'b0; sub_mode_i = 1'b0; rnd_valid_i = 1'b0;
    src_a_base_i = '0; src_b_base_i = '0; dst_base_i = '0;
    cyc = 0; n_checks = 0; n_fail = 0; exp_mode = 1'b0;
    clear_stats();
    test_reset();
    test_add_contig();
    test_sub_bubbles();
    test_wraparound();
    test_zeroize();
    test_busy_start();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
